// File: rtl/hovalaag_word_tx.sv
// Word-to-chunk serializer feeding the Hovalaag core's narrow data input pins.
// A 2-entry FIFO buffers words, which go out least-significant chunk first with first/last strobes.
module hovalaag_word_tx #(
    parameter int WORD_W     = 12,
    parameter int CHUNK_W    = 6,
    parameter int GAP_CYCLES = 0,
    parameter int IDLE_VAL   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  in_word,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    output logic [CHUNK_W-1:0] chunk_out,
    output logic               chunk_valid,
    output logic               chunk_first,
    output logic               chunk_last,
    output logic               busy,
    output logic [1:0]         fifo_level
);

    // state | meaning
    // IDLE  | nothing being sent; pops the FIFO head as soon as one is buffered
    // SEND  | chunk_out carries chunk cnt of the word in the shift register
    // GAP   | idle spacing after a word's last chunk, counted down by gap_q
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int NCHUNK = WORD_W / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(NCHUNK - 1);
    localparam logic [3:0]         GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [CHUNK_W-1:0] IDLE_CHUNK = CHUNK_W'(IDLE_VAL);

    state_t              state_q, state_nx;
    logic [WORD_W-1:0]   fifo_mem [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          level_q, level_nx;
    logic [WORD_W-1:0]   shift_q, shift_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic [3:0]          gap_q, gap_nx;
    logic                push, pop;

    // Ready is taken from the registered level only, so a full FIFO refuses a push even when it pops.
    assign in_ready   = !rst && (level_q != 2'd2);
    assign push       = in_valid && in_ready;
    assign fifo_level = level_q;

    always_comb begin
        state_nx = state_q;
        shift_nx = shift_q;
        cnt_nx   = cnt_q;
        gap_nx   = gap_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != 2'd0) begin
                    pop      = 1'b1;
                    shift_nx = fifo_mem[rd_ptr_q];
                    cnt_nx   = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (!stall) begin
                    if (cnt_q != LAST_CNT) begin
                        shift_nx = shift_q >> CHUNK_W;
                        cnt_nx   = cnt_q + CNT_W'(1);
                    end else if (GAP_CYCLES == 0) begin
                        if (level_q != 2'd0) begin
                            pop      = 1'b1;
                            shift_nx = fifo_mem[rd_ptr_q];
                            cnt_nx   = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        gap_nx   = GAP_LOAD;
                        state_nx = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    if (level_q != 2'd0) begin
                        pop      = 1'b1;
                        shift_nx = fifo_mem[rd_ptr_q];
                        cnt_nx   = '0;
                        state_nx = SEND;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    gap_nx = gap_q - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        level_nx = level_q + {1'b0, push} - {1'b0, pop};
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            level_q     <= 2'd0;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= 4'd0;
            chunk_out   <= IDLE_CHUNK;
            chunk_valid <= 1'b0;
            chunk_first <= 1'b0;
            chunk_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= in_word;
                wr_ptr_q           <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
            state_q     <= state_nx;
            level_q     <= level_nx;
            shift_q     <= shift_nx;
            cnt_q       <= cnt_nx;
            gap_q       <= gap_nx;
            chunk_valid <= (state_nx == SEND);
            chunk_out   <= (state_nx == SEND) ? shift_nx[CHUNK_W-1:0] : IDLE_CHUNK;
            chunk_first <= (state_nx == SEND) && (cnt_nx == '0);
            chunk_last  <= (state_nx == SEND) && (cnt_nx == LAST_CNT);
            busy        <= (state_nx != IDLE) || (level_nx != 2'd0);
        end
    end

endmodule

// File: tb/tb_hovalaag_word_tx.sv
// Directed bench for hovalaag_word_tx: one instance without inter-word gap, one with GAP_CYCLES=2.
module tb_hovalaag_word_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [11:0] in_word0 = '0, in_word1 = '0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic        stall0 = 1'b0, stall1 = 1'b0;
    logic        in_ready0, in_ready1;
    logic [5:0]  chunk_out0, chunk_out1;
    logic        chunk_valid0, chunk_valid1, chunk_first0, chunk_first1, chunk_last0, chunk_last1;
    logic        busy0, busy1;
    logic [1:0]  fifo_level0, fifo_level1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hovalaag_word_tx #(.WORD_W(12), .CHUNK_W(6), .GAP_CYCLES(0), .IDLE_VAL(0)) dut0 (
        .clk(clk), .rst(rst), .in_word(in_word0), .in_valid(in_valid0), .in_ready(in_ready0),
        .stall(stall0), .chunk_out(chunk_out0), .chunk_valid(chunk_valid0),
        .chunk_first(chunk_first0), .chunk_last(chunk_last0), .busy(busy0), .fifo_level(fifo_level0)
    );

    hovalaag_word_tx #(.WORD_W(12), .CHUNK_W(6), .GAP_CYCLES(2), .IDLE_VAL(0)) dut1 (
        .clk(clk), .rst(rst), .in_word(in_word1), .in_valid(in_valid1), .in_ready(in_ready1),
        .stall(stall1), .chunk_out(chunk_out1), .chunk_valid(chunk_valid1),
        .chunk_first(chunk_first1), .chunk_last(chunk_last1), .busy(busy1), .fifo_level(fifo_level1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp0(input string tag, input logic v, input logic [5:0] c, input logic f, input logic l);
        chk({tag, "_valid"}, 32'(chunk_valid0), 32'(v));
        chk({tag, "_chunk"}, 32'(chunk_out0), 32'(c));
        chk({tag, "_first"}, 32'(chunk_first0), 32'(f));
        chk({tag, "_last"}, 32'(chunk_last0), 32'(l));
    endtask

    task automatic exp1(input string tag, input logic v, input logic [5:0] c, input logic f, input logic l);
        chk({tag, "_valid"}, 32'(chunk_valid1), 32'(v));
        chk({tag, "_chunk"}, 32'(chunk_out1), 32'(c));
        chk({tag, "_first"}, 32'(chunk_first1), 32'(f));
        chk({tag, "_last"}, 32'(chunk_last1), 32'(l));
    endtask

    logic [11:0] words [4];
    logic [5:0]  exp_chunks [8];

    initial begin
        int  got;
        logic acc;

        // reset held for two edges
        step();
        step();
        chk("rst_in_ready", 32'(in_ready0), 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready0), 1);
        exp0("rel", 1'b0, 6'h00, 1'b0, 1'b0);
        chk("rel_busy", 32'(busy0), 0);
        chk("rel_level", 32'(fifo_level0), 0);

        // single word
        in_word0 = 12'hABC; in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        chk("t2_busy_c1", 32'(busy0), 1);
        chk("t2_valid_c1", 32'(chunk_valid0), 0);
        step();
        exp0("t2_c2", 1'b1, 6'h3C, 1'b1, 1'b0);
        step();
        exp0("t2_c3", 1'b1, 6'h2A, 1'b0, 1'b1);
        step();
        exp0("t2_c4", 1'b0, 6'h00, 1'b0, 1'b0);
        chk("t2_busy_c4", 32'(busy0), 0);

        // back-to-back words with no gap
        in_word0 = 12'hABC; in_valid0 = 1'b1;
        step();
        in_word0 = 12'h123;
        chk("t3_in_ready_c1", 32'(in_ready0), 1);
        step();
        in_valid0 = 1'b0;
        exp0("t3_c2", 1'b1, 6'h3C, 1'b1, 1'b0);
        step();
        exp0("t3_c3", 1'b1, 6'h2A, 1'b0, 1'b1);
        step();
        exp0("t3_c4", 1'b1, 6'h23, 1'b1, 1'b0);
        step();
        exp0("t3_c5", 1'b1, 6'h04, 1'b0, 1'b1);
        step();
        exp0("t3_c6", 1'b0, 6'h00, 1'b0, 1'b0);

        // stall holds the first chunk for three extra cycles
        in_word0 = 12'hABC; in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        step();
        stall0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall0 = 1'b0;
            exp0($sformatf("t4_hold%0d", i), 1'b1, 6'h3C, 1'b1, 1'b0);
            step();
        end
        exp0("t4_second", 1'b1, 6'h2A, 1'b0, 1'b1);
        step();
        exp0("t4_done", 1'b0, 6'h00, 1'b0, 1'b0);

        // back-pressure: FIFO fills while the consumer stalls
        words      = '{12'h105, 12'h20A, 12'h30F, 12'hFD3};
        exp_chunks = '{6'h05, 6'h04, 6'h0A, 6'h08, 6'h0F, 6'h0C, 6'h13, 6'h3F};
        stall0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_word0 = words[i]; in_valid0 = 1'b1;
            chk($sformatf("t5_ready%0d", i), 32'(in_ready0), 1);
            step();
        end
        in_word0 = words[3];
        chk("t5_full_ready", 32'(in_ready0), 0);
        chk("t5_full_level", 32'(fifo_level0), 2);
        exp0("t5_held", 1'b1, 6'h05, 1'b1, 1'b0);
        step();
        chk("t5_full_ready2", 32'(in_ready0), 0);
        stall0 = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (chunk_valid0) begin
                chk($sformatf("t5_chunk%0d", got), 32'(chunk_out0), 32'(exp_chunks[got]));
                chk($sformatf("t5_first%0d", got), 32'(chunk_first0), 32'((got % 2) == 0));
                chk($sformatf("t5_last%0d", got), 32'(chunk_last0), 32'((got % 2) == 1));
                got++;
            end
            acc = in_valid0 && in_ready0;
            step();
            if (acc) in_valid0 = 1'b0;
        end
        chk("t5_count", 32'(got), 8);
        step();
        chk("t5_idle_busy", 32'(busy0), 0);

        // two words with a two-cycle gap between them
        in_word1 = 12'hABC; in_valid1 = 1'b1;
        step();
        in_word1 = 12'h123;
        step();
        in_valid1 = 1'b0;
        exp1("t6_c2", 1'b1, 6'h3C, 1'b1, 1'b0);
        step();
        exp1("t6_c3", 1'b1, 6'h2A, 1'b0, 1'b1);
        step();
        exp1("t6_gap0", 1'b0, 6'h00, 1'b0, 1'b0);
        chk("t6_gap_busy", 32'(busy1), 1);
        step();
        exp1("t6_gap1", 1'b0, 6'h00, 1'b0, 1'b0);
        step();
        exp1("t6_c6", 1'b1, 6'h23, 1'b1, 1'b0);
        step();
        exp1("t6_c7", 1'b1, 6'h04, 1'b0, 1'b1);
        step();
        step();
        step();
        exp1("t6_end", 1'b0, 6'h00, 1'b0, 1'b0);
        chk("t6_end_busy", 32'(busy1), 0);

        // reset in the middle of a word
        in_word1 = 12'hABC; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        exp1("t6r_first", 1'b1, 6'h3C, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        exp1("t6r_rst", 1'b0, 6'h00, 1'b0, 1'b0);
        chk("t6r_busy", 32'(busy1), 0);
        chk("t6r_level", 32'(fifo_level1), 0);
        chk("t6r_in_ready", 32'(in_ready1), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t6r_after%0d", i), 32'(chunk_valid1), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hovalaag_word_tx.md
Name: hovalaag_word_tx

Overview:
Host-side transmitter that feeds the Hovalaag core's narrow 6-bit data input pins. It accepts full-width data words over a valid/ready handshake, buffers them in a 2-entry FIFO, and serializes each word into CHUNK_W-bit chunks, least-significant chunk first, one chunk per accepted transfer. Frame strobes (first/last) and consumer back-pressure (stall) let the core's input side reassemble words. Used in the bench/host harness and in on-chip loopback tests.

Parameters:
WORD_W, 12, width of one parallel data word; must be an integer multiple of CHUNK_W.
CHUNK_W, 6, width of one serialized chunk (matches core data input pins).
GAP_CYCLES, 0, idle cycles inserted after each word's last chunk (0..15).
IDLE_VAL, 0, value driven on chunk_out whenever chunk_valid=0.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
in_word  input  WORD_W  word to transmit.
in_valid  input  1  in_word valid.
in_ready  output  1  block can accept a word this cycle.
stall  input  1  consumer not taking the current chunk.
chunk_out  output  CHUNK_W  current chunk.
chunk_valid  output  1  chunk_out holds a real chunk.
chunk_first  output  1  current chunk is chunk 0 of a word.
chunk_last  output  1  current chunk is chunk NCHUNK-1 of a word.
busy  output  1  word in flight or buffered.
fifo_level  output  2  FIFO occupancy, 0..2.

Behaviour:
- Single clock clk; reset is synchronous and active-high on rst. NCHUNK = WORD_W/CHUNK_W.
- Reset (rst=1 at edge): state IDLE, FIFO empty, fifo_level=0, chunk counter 0, gap counter 0, chunk_out=IDLE_VAL, chunk_valid/first/last=0, busy=0. in_ready forced 0 while rst=1; 1 in first cycle after. Reset mid-word discards the word and all buffered words; no partial frame resumes.
- Input handshake: push when in_valid && in_ready. in_ready = !rst && fifo_level<2, from registered level only; a full FIFO refuses a push even when a pop occurs in the same cycle. in_word sampled at the push edge only.
- Chunk transfer occurs on any cycle with chunk_valid=1 and stall=0. While stall=1, chunk_out, first, last, and counters hold unchanged. stall ignored when chunk_valid=0.
- FSM:
  IDLE: chunk_valid=0. If FIFO non-empty: pop head into shift register, counter=0, go to SEND.
  SEND: chunk_valid=1, chunk_out=shift[CHUNK_W-1:0], first=(counter==0), last=(counter==NCHUNK-1). On transfer with counter<NCHUNK-1: shift right by CHUNK_W, counter+1. On transfer of last chunk: if GAP_CYCLES=0 and FIFO non-empty, pop and reload, stay in SEND (back-to-back, no bubble); if GAP_CYCLES=0 and FIFO empty, go to IDLE; else load gap counter, go to GAP.
  GAP: chunk_valid=0, chunk_out=IDLE_VAL. Decrement each cycle; at expiry go to SEND with pop if FIFO non-empty, else IDLE.
- Latency: word pushed at edge of cycle N into empty, idle block: chunk 0 valid in cycle N+2.
- Push and pop in same cycle: level unchanged, order preserved.
- All outputs are registered except in_ready.
- busy = (state!=IDLE) || fifo_level!=0.
- NCHUNK=1: first and last both 1 on the single chunk.

Test Plan:
1. Reset: hold rst 2 cycles, release -> chunk_out=0, chunk_valid=0, busy=0, fifo_level=0; in_ready=0 during rst, 1 in cycle after release.
2. Single word: push 0xABC in cycle 0, stall=0 -> cycle 2: chunk 0x3C, first=1, last=0. Cycle 3: 0x2A, last=1. Cycle 4: chunk_valid=0, busy=0.
3. Back-to-back, GAP_CYCLES=0: push 0xABC then 0x123 on consecutive cycles -> chunks 0x3C, 0x2A, 0x23, 0x04 on four consecutive cycles; first at 0x3C/0x23, last at 0x2A/0x04.
4. Stall: push 0xABC, assert stall for 3 cycles starting when 0x3C appears -> 0x3C with first=1 held 4 cycles, then 0x2A for 1 cycle.
5. Back-pressure: stall=1 throughout, in_valid=1 with four words -> words 0,1,2 accepted in cycles 0,1,2; in_ready=0 from cycle 3 with fifo_level=2. Release stall -> all four words serialized in push order.
6. Gap and reset, GAP_CYCLES=2: two words back-to-back -> 2 idle cycles with chunk_out=0 between 0x2A and 0x23. Then push 0xABC and assert rst in the cycle 0x3C is shown -> next cycle all outputs at reset values; 0x2A never appears.
